// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects the next PC among boot vector, sequential,
// jump/branch redirect, stall and halt, and squashes IF/ID during redirect penalty windows.
module pc_sequencer #(
  parameter int                  PC_WIDTH       = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR   = {PC_WIDTH{1'b0}},
  parameter int                  BRANCH_PENALTY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                halt,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic                pc_write,
  output logic                flush,
  output logic [1:0]          state,
  output logic [7:0]          redirect_count
);

  typedef enum logic [1:0] {
    BOOT     = 2'b00,
    RUN      = 2'b01,
    REDIRECT = 2'b10,
    HALT     = 2'b11
  } state_t;

  localparam logic [3:0] PEN_LOAD = 4'(BRANCH_PENALTY - 1);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [3:0]          pen_r;
  logic [3:0]          pen_nxt_s;
  logic [7:0]          rcnt_r;
  logic                redirect_s;
  logic [PC_WIDTH-1:0] pc_inc_s;
  logic [PC_WIDTH-1:0] target_s;

  assign pc_inc_s       = pc_in + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign target_s       = jump ? jump_target : branch_target;
  assign state          = state_r;
  assign redirect_count = rcnt_r;

  // Next-state and PC selection; outputs are combinational so a redirect costs no extra cycle
  always_comb begin
    state_nxt_s = state_r;
    pen_nxt_s   = pen_r;
    pc_next     = pc_in;
    pc_write    = 1'b0;
    flush       = 1'b0;
    redirect_s  = 1'b0;
    case (state_r)
      BOOT: begin
        pc_next     = RESET_VECTOR;
        pc_write    = 1'b1;
        flush       = 1'b1;
        state_nxt_s = RUN;
      end
      RUN: begin
        if (halt) begin
          state_nxt_s = HALT;
        end else if (jump || branch_taken) begin
          pc_next    = target_s;
          pc_write   = 1'b1;
          flush      = 1'b1;
          redirect_s = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            state_nxt_s = REDIRECT;
            pen_nxt_s   = PEN_LOAD;
          end else begin
            state_nxt_s = RUN;
            pen_nxt_s   = 4'd0;
          end
        end else if (stall) begin
          pc_write = 1'b0;
        end else begin
          pc_next  = pc_inc_s;
          pc_write = 1'b1;
        end
      end
      REDIRECT: begin
        // Requests here come from squashed instructions and are ignored
        pc_next   = pc_inc_s;
        pc_write  = 1'b1;
        flush     = 1'b1;
        pen_nxt_s = pen_r - 4'd1;
        if (pen_r <= 4'd1) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = REDIRECT;
        end
      end
      HALT: begin
        state_nxt_s = HALT;
      end
      default: begin
        state_nxt_s = BOOT;
        pen_nxt_s   = 4'd0;
      end
    endcase
    if (rst) begin
      pc_next  = RESET_VECTOR;
      pc_write = 1'b1;
      flush    = 1'b1;
    end else begin
      pc_write = pc_write;
    end
  end

  // State, penalty counter and saturating redirect counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BOOT;
      pen_r   <= 4'd0;
      rcnt_r  <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      pen_r   <= pen_nxt_s;
      if (redirect_s && (rcnt_r != 8'hFF)) begin
        rcnt_r <= rcnt_r + 8'd1;
      end
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 16: width of all program-counter buses.
REQ-002 Parameter RESET_VECTOR, default 16'h0000: first fetch address after reset.
REQ-003 Parameter BRANCH_PENALTY, default 2, legal range 1..15: number of flush cycles per redirect, counting the redirect cycle itself.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port pc_in, input, PC_WIDTH bits: current PC, taken from the PC register output.
REQ-007 Port stall, input, 1 bit: load-use hazard request to hold the PC.
REQ-008 Port branch_taken, input, 1 bit: resolved taken branch.
REQ-009 Port branch_target, input, PC_WIDTH bits: branch destination.
REQ-010 Port jump, input, 1 bit: unconditional jump request.
REQ-011 Port jump_target, input, PC_WIDTH bits: jump destination.
REQ-012 Port halt, input, 1 bit: halt-instruction request.
REQ-013 Port pc_next, output, PC_WIDTH bits: value driven into the PC register input.
REQ-014 Port pc_write, output, 1 bit: PC register load enable.
REQ-015 Port flush, output, 1 bit: squash signal for the IF/ID stage.
REQ-016 Port state, output, 2 bits: current FSM state.
REQ-017 Port redirect_count, output, 8 bits: saturating count of taken redirects.

Function
REQ-018 The FSM SHALL have four states: BOOT=2'b00, RUN=2'b01, REDIRECT=2'b10, HALT=2'b11; the state output SHALL equal the state register.
REQ-019 pc_next, pc_write and flush SHALL be combinational functions of the state register, the penalty counter and the current-cycle inputs, so that a redirect takes effect with zero added latency.
REQ-020 In BOOT: pc_next=RESET_VECTOR, pc_write=1, flush=1; the next state SHALL be RUN unconditionally.
REQ-021 In RUN, request priority SHALL be halt > jump > branch_taken > stall > sequential.
REQ-022 RUN with halt=1: pc_write=0, pc_next=pc_in, flush=0; the next state SHALL be HALT.
REQ-023 RUN with jump=1: pc_next=jump_target, pc_write=1, flush=1, and redirect_count SHALL increment.
REQ-024 RUN with branch_taken=1 and jump=0: pc_next=branch_target, pc_write=1, flush=1, and redirect_count SHALL increment.
REQ-025 On a redirect with BRANCH_PENALTY>1: the penalty counter SHALL load BRANCH_PENALTY-1 and the next state SHALL be REDIRECT. With BRANCH_PENALTY=1 the state SHALL remain RUN.
REQ-026 RUN with stall=1 and no higher-priority request: pc_write=0, pc_next=pc_in, flush=0.
REQ-027 RUN with no request: pc_next=pc_in+1 modulo 2^PC_WIDTH (16'hFFFF wraps to 16'h0000), pc_write=1, flush=0.
REQ-028 In REDIRECT: flush=1, pc_write=1, pc_next=pc_in+1 (with wrap); stall, halt, jump and branch_taken SHALL be ignored because they originate from squashed instructions.
REQ-029 In REDIRECT the penalty counter SHALL decrement each cycle; the cycle in which it reaches 1 SHALL be the last REDIRECT cycle, with the next state RUN.
REQ-030 In HALT: pc_write=0, pc_next=pc_in, flush=0; the FSM SHALL stay in HALT until rst.
REQ-031 redirect_count SHALL saturate at 8'hFF and never wrap.

Reset
REQ-032 rst=1 at a clock edge SHALL force state<=BOOT, penalty counter<=0 and redirect_count<=0, from any state including mid-REDIRECT and HALT.
REQ-033 While rst=1, outputs SHALL follow the BOOT row: pc_next=RESET_VECTOR, pc_write=1, flush=1.
REQ-034 rst SHALL take priority over every request input in the same cycle.

Verification
REQ-035 Hold rst=1 for 1 cycle, then release with pc_in=0 -> one BOOT cycle (pc_next=0, flush=1), then RUN; pc_next tracks pc_in+1, so with pc_in=5 pc_next=6.
REQ-036 In RUN, pc_in=16'h0010, branch_taken=1, branch_target=16'h0040, BRANCH_PENALTY=2 -> pc_next=16'h0040 and flush=1 that cycle; one REDIRECT cycle with flush=1 in which jump=1 is ignored; then RUN; redirect_count=1.
REQ-037 Same cycle jump=1 (jump_target=16'h0100), branch_taken=1 (branch_target=16'h0200), stall=1 -> pc_next=16'h0100, pc_write=1.
REQ-038 RUN with stall=1 for 3 cycles at pc_in=16'h0007 -> pc_write=0 for those 3 cycles; then pc_next=16'h0008.
REQ-039 pc_in=16'hFFFF in RUN with no request -> pc_next=16'h0000; halt=1 -> HALT with pc_write=0; rst=1 -> BOOT.
REQ-040 Drive 300 redirects separated by full penalty windows -> redirect_count=8'hFF; assert rst=1 during REDIRECT -> state=BOOT and redirect_count=0 on the next cycle.
